// File: rtl/p_mul_seq_if.sv
// Operand/result handshake bundle for the sequential packed multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface p_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  pw;
    logic        clmul;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    modport master (
        output in_valid, lhs, rhs, pw, clmul, out_ready,
        input  in_ready, out_valid, result_lo, result_hi
    );

    modport slave (
        input  in_valid, lhs, rhs, pw, clmul, out_ready,
        output in_ready, out_valid, result_lo, result_hi
    );
endinterface

// File: rtl/p_mul_seq.sv
// Sequential packed multiplier: one multiplier bit per cycle per lane, full 2w-bit lane products.
// Define P_MUL_SEQ_CLMUL_EN to build the carry-less (XOR) multiply mode selected by clmul.
module p_mul_seq (
    input  logic       g_clk,
    input  logic       g_rst,
    p_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [2:0]  wsel_reg, wsel_next;
    logic [31:0] lhs_reg, lhs_next;
    logic [63:0] acc_reg, acc_next;
`ifdef P_MUL_SEQ_CLMUL_EN
    logic        clmul_reg, clmul_next;
`else
    logic        unused_clmul;
    assign unused_clmul = bus.clmul;
`endif

    // Width select index: 0..4 maps to lane width 32 >> index.
    logic [2:0] wsel_in;
    logic [4:0] count_init;

    always_comb begin
        wsel_in = 3'd0;
        if (bus.pw[0])      wsel_in = 3'd0;
        else if (bus.pw[1]) wsel_in = 3'd1;
        else if (bus.pw[2]) wsel_in = 3'd2;
        else if (bus.pw[3]) wsel_in = 3'd3;
        else if (bus.pw[4]) wsel_in = 3'd4;
    end

    assign count_init = 5'((6'd32 >> wsel_in) - 6'd1);

    logic [4:0][63:0] load_acc;
    logic [4:0][63:0] step_acc;
    logic [4:0][31:0] res_lo;
    logic [4:0][31:0] res_hi;

    // Every lane of width W owns a 2W-bit field {hi, lo}; lo starts as the multiplier
    // and its LSB is the multiplier bit consumed by the current step.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_width
            localparam int W = 32 >> gi;
            for (genvar gj = 0; gj < 32 / W; gj++) begin : g_lane
                logic [2*W-1:0] field;
                logic [W-1:0]   addend;
                logic [W:0]     sum;

                assign field  = acc_reg[2*W*gj +: 2*W];
                assign addend = field[0] ? lhs_reg[W*gj +: W] : '0;
`ifdef P_MUL_SEQ_CLMUL_EN
                assign sum = clmul_reg ? {1'b0, field[2*W-1:W] ^ addend}
                                       : {1'b0, field[2*W-1:W]} + {1'b0, addend};
`else
                assign sum = {1'b0, field[2*W-1:W]} + {1'b0, addend};
`endif
                assign step_acc[gi][2*W*gj +: 2*W] = {sum, field[W-1:1]};
                assign load_acc[gi][2*W*gj +: 2*W] = {{W{1'b0}}, bus.rhs[W*gj +: W]};
                assign res_lo[gi][W*gj +: W]       = field[W-1:0];
                assign res_hi[gi][W*gj +: W]       = field[2*W-1:W];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wsel_next  = wsel_reg;
        lhs_next   = lhs_reg;
        acc_next   = acc_reg;
`ifdef P_MUL_SEQ_CLMUL_EN
        clmul_next = clmul_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    state_next = BUSY;
                    count_next = count_init;
                    wsel_next  = wsel_in;
                    lhs_next   = bus.lhs;
                    acc_next   = load_acc[wsel_in];
`ifdef P_MUL_SEQ_CLMUL_EN
                    clmul_next = bus.clmul;
`endif
                end
            end
            BUSY: begin
                acc_next = step_acc[wsel_reg];
                if (count_reg == 5'd0) state_next = DONE;
                else                   count_next = count_reg - 5'd1;
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_reg <= IDLE;
            count_reg <= 5'd0;
            wsel_reg  <= 3'd0;
            lhs_reg   <= 32'd0;
            acc_reg   <= 64'd0;
`ifdef P_MUL_SEQ_CLMUL_EN
            clmul_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            wsel_reg  <= wsel_next;
            lhs_reg   <= lhs_next;
            acc_reg   <= acc_next;
`ifdef P_MUL_SEQ_CLMUL_EN
            clmul_reg <= clmul_next;
`endif
        end
    end

    assign bus.in_ready  = (state_reg == IDLE) && !g_rst;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result_lo = res_lo[wsel_reg];
    assign bus.result_hi = res_hi[wsel_reg];
endmodule

// File: tb/tb_p_mul_seq.sv
// Randomized self-checking bench for p_mul_seq against a lane-wise arithmetic product model.
module tb_p_mul_seq;
`ifdef P_MUL_SEQ_CLMUL_EN
    localparam bit CLMUL_ON = 1'b1;
`else
    localparam bit CLMUL_ON = 1'b0;
`endif

    logic g_clk;
    logic g_rst;
    p_mul_seq_if bus ();

    p_mul_seq dut (.g_clk(g_clk), .g_rst(g_rst), .bus(bus));

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    function automatic int model_w(input logic [4:0] p);
        if (p[0]) return 32;
        if (p[1]) return 16;
        if (p[2]) return 8;
        if (p[3]) return 4;
        if (p[4]) return 2;
        return 32;
    endfunction

    // Returns {hi, lo}: each lane's full product split into its low and high w bits.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] p, input logic cl);
        int w;
        logic [63:0] mask, x, y, prod;
        logic [31:0] lo, hi;
        w = model_w(p);
        mask = (64'd1 << w) - 64'd1;
        lo = '0;
        hi = '0;
        for (int l = 0; l < 32 / w; l++) begin
            x = (64'(a) >> (l * w)) & mask;
            y = (64'(b) >> (l * w)) & mask;
            if (cl && CLMUL_ON) begin
                prod = '0;
                for (int i = 0; i < w; i++) if (y[i]) prod = prod ^ (x << i);
            end else begin
                prod = x * y;
            end
            lo = lo | 32'((prod & mask) << (l * w));
            hi = hi | 32'(((prod >> w) & mask) << (l * w));
        end
        return {hi, lo};
    endfunction

    // Issues one operation and waits for out_valid; ok=0 if either wait expires.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] p,
                          input logic cl, output logic [31:0] lo, output logic [31:0] hi,
                          output int lat, output bit ok);
        int n;
        ok = 1'b1;
        lat = 0;
        lo = '0;
        hi = '0;
        n = 0;
        while (!bus.in_ready && n < 100) begin tick(); n++; end
        if (!bus.in_ready) begin ok = 1'b0; return; end
        bus.in_valid = 1'b1;
        bus.lhs = a;
        bus.rhs = b;
        bus.pw = p;
        bus.clmul = cl;
        tick();
        bus.in_valid = 1'b0;
        bus.lhs = $urandom;
        bus.rhs = $urandom;
        bus.pw = 5'($urandom);
        bus.clmul = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 100) begin tick(); n++; end
        if (!bus.out_valid) begin ok = 1'b0; return; end
        lat = n;
        lo = bus.result_lo;
        hi = bus.result_hi;
        $display("op pw=%b cl=%0d lhs=%h rhs=%h -> lo=%h hi=%h lat=%0d", p, cl, a, b, lo, hi, lat);
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        g_rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        vectors++;
        if (bus.result_lo !== 32'd0 || bus.result_hi !== 32'd0) begin
            miscompares++; $display("FAIL reset_result got lo=%h hi=%h want 0", bus.result_lo, bus.result_hi);
        end
        g_rst = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
        $display("reset checked");
    endtask

    task automatic test_directed();
        logic [31:0] ta [5] = '{32'hFFFFFFFF, 32'h02FF1003, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3};
        logic [31:0] tb [5] = '{32'hFFFFFFFF, 32'h03FF1005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3};
        logic [4:0]  tp [5] = '{5'b00001, 5'b00100, 5'b10000, 5'b00000, 5'b00001};
        logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] el [5] = '{32'h00000001, 32'h0601000F, 32'h55555555, 32'h00000001,
                                (CLMUL_ON ? 32'h5 : 32'h9)};
        logic [31:0] eh [5] = '{32'hFFFFFFFE, 32'h00FE0100, 32'hAAAAAAAA, 32'hFFFFFFFE, 32'h0};
        int          ew [5] = '{32, 8, 2, 32, 32};
        logic [31:0] lo, hi;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tp[i], tc[i], lo, hi, lat, ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL directed%0d_timeout got=timeout want=out_valid", i); end
            vectors++;
            if (lo !== el[i]) begin miscompares++; $display("FAIL directed%0d_lo got=%h want=%h", i, lo, el[i]); end
            vectors++;
            if (hi !== eh[i]) begin miscompares++; $display("FAIL directed%0d_hi got=%h want=%h", i, hi, eh[i]); end
            vectors++;
            if (lat != ew[i]) begin miscompares++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, ew[i]); end
            retire();
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed%0d_retire got ov=%b ir=%b want ov=0 ir=1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, lo, hi;
        logic [4:0] p;
        logic cl;
        logic [63:0] exp;
        int lat, k;
        bit ok;
        for (int i = 0; i < 30; i++) begin
            k = int'($urandom_range(0, 5));
            p = (k < 5) ? 5'(1 << k) : 5'($urandom);
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            cl = 1'($urandom);
            exp = model(a, b, p, cl);
            run_op(a, b, p, cl, lo, hi, lat, ok);
            vectors++;
            if (!ok || {hi, lo} !== exp || lat != model_w(p)) begin
                miscompares++;
                $display("FAIL random%0d got ok=%0d hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, ok, hi, lo, lat, exp[63:32], exp[31:0], model_w(p));
            end
            retire();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, lo, hi;
        logic [63:0] exp;
        int lat;
        bit ok, stable;
        a = $urandom;
        b = $urandom;
        exp = model(a, b, 5'b00100, 1'b0);
        run_op(a, b, 5'b00100, 1'b0, lo, hi, lat, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL bp_timeout got=timeout want=out_valid"); end
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            bus.lhs = $urandom;
            bus.rhs = $urandom;
            bus.pw = 5'b10000;
            tick();
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                {bus.result_hi, bus.result_lo} !== exp) stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL bp_hold got ov=%b ir=%b hi=%h lo=%h want ov=1 ir=0 hi=%h lo=%h",
                     bus.out_valid, bus.in_ready, bus.result_hi, bus.result_lo, exp[63:32], exp[31:0]);
        end
        retire();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_ignored_pulses got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
        end
        $display("backpressure held 10 cycles");
    endtask

    task automatic test_reset_mid();
        logic [31:0] lo, hi;
        int lat;
        bit ok, seen;
        bus.in_valid = 1'b1;
        bus.lhs = 32'hFFFFFFFF;
        bus.rhs = 32'hFFFFFFFF;
        bus.pw = 5'b00001;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        g_rst = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready got=%b want=0", bus.in_ready); end
        tick();
        g_rst = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.result_lo !== 32'd0 || bus.result_hi !== 32'd0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state got ov=%b ir=%b lo=%h hi=%h want ov=0 ir=1 lo=0 hi=0",
                     bus.out_valid, bus.in_ready, bus.result_lo, bus.result_hi);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL midrst_no_valid got=out_valid want=none"); end
        run_op(32'h00030003, 32'h00050005, 5'b00010, 1'b0, lo, hi, lat, ok);
        vectors++;
        if (!ok || lo !== 32'h000F000F || hi !== 32'd0 || lat != 16) begin
            miscompares++;
            $display("FAIL midrst_next_op got ok=%0d lo=%h hi=%h lat=%0d want lo=000f000f hi=0 lat=16", ok, lo, hi, lat);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [63:0] q [$];
        logic [63:0] exp;
        int last, got, pushed;
        last = -1;
        got = 0;
        pushed = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
            if (bus.out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : 64'hX;
                vectors++;
                if ({bus.result_hi, bus.result_lo} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b%0d_result got hi=%h lo=%h want hi=%h lo=%h",
                             got, bus.result_hi, bus.result_lo, exp[63:32], exp[31:0]);
                end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 6) begin
                        miscompares++; $display("FAIL b2b%0d_spacing got=%0d want=6", got, cyc - last);
                    end
                end
                $display("b2b result %0d hi=%h lo=%h at cycle %0d", got, bus.result_hi, bus.result_lo, cyc);
                last = cyc;
                got++;
            end
            if (bus.in_ready) begin
                if (pushed < 4) begin
                    bus.in_valid = 1'b1;
                    bus.lhs = $urandom;
                    bus.rhs = $urandom;
                    bus.pw = 5'b01000;
                    bus.clmul = 1'b0;
                    q.push_back(model(bus.lhs, bus.rhs, 5'b01000, 1'b0));
                    pushed++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (got != 4) begin miscompares++; $display("FAIL b2b_count got=%0d want=4", got); end
    endtask

    initial begin
        g_rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.lhs = '0;
        bus.rhs = '0;
        bus.pw = '0;
        bus.clmul = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/p_mul_seq.md
# p_mul_seq

Sequential packed multiplier for the packed-arithmetic unit. It takes two 32-bit operands and a one-hot pack width, and produces the full double-width product of every lane: low halves in `result_lo`, high halves in `result_hi`. It sits beside the combinational packed add/sub and consumes lane-masked carries in the same way, iterating one multiplier bit per cycle. It uses a valid/ready handshake on both input and output.

## Interface
- No parameters.
- `g_clk`  in  1  clock; all state updates on the rising edge.
- `g_rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `lhs`  in  32  multiplicand, packed lanes.
- `rhs`  in  32  multiplier, packed lanes.
- `pw`  in  5  one-hot pack width: bit0 = 32, bit1 = 16, bit2 = 8, bit3 = 4, bit4 = 2.
- `clmul`  in  1  carry-less multiply select; effective only with the configuration macro.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result_lo`  out  32  low w bits of each lane product, packed at lane position.
- `result_hi`  out  32  high w bits of each lane product, packed at lane position.

## Operation
- **Lane width w.** Decoded at accept with priority 32 > 16 > 8 > 4 > 2. `pw == 0` is treated as 32. Operands, w and the clmul mode are latched at accept; later input changes have no effect.
- **State machine.**
  - IDLE: `in_ready=1`. On `in_valid`, latch and go to BUSY with the step counter = w-1.
  - BUSY: each cycle performs one step per lane. Counter == 0 → DONE; else decrement.
  - DONE: `out_valid=1`. On `out_ready` → IDLE.
  - `in_ready` is low in BUSY and DONE. There is no accept in the same cycle as output retire.
- **Datapath.** A 64-bit accumulator holds one 2w-bit field per lane (hi part, lo part). Step k, per lane:
  - If multiplier bit k of the lane is 1, add the lane `lhs` into the lane hi part. Add with carry out, w+1 bits, carries masked at lane boundaries.
  - Shift the lane's 2w-bit field right by one. The carry out enters the MSB.
- **Unsigned only.** Products are exact for all inputs, including all-ones operands. No overflow is possible.
- **clmul mode.** Addition is replaced by bitwise XOR and the carry is forced to 0.
- **Outputs.** `result_lo`/`result_hi` are driven from the accumulator. They are stable and held throughout DONE regardless of `out_ready`. They are don't-care outside DONE but must not contain X after reset.
- **Reset values.**
  - `in_ready=0` while `g_rst` is high, then 1 in IDLE.
  - `out_valid=0`, `result_lo=0`, `result_hi=0`, state IDLE, counter 0.
- **Reset mid-operation.** Reset in BUSY or DONE abandons the operation: IDLE, accumulator cleared, no `out_valid` pulse.

## Timing
- Accept edge T, where `in_valid && in_ready`.
- Steps occur at edges T+1 … T+w.
- `out_valid` is first high in the cycle after edge T+w, i.e. latency w cycles: 32, 16, 8, 4 or 2.
- Retire edge R, where `out_valid && out_ready`. `in_ready` is high from cycle R+1.
- Back-to-back throughput is one operation per w+2 cycles.
- The add and shift of one step complete in a single cycle; there is no multicycle path.

## Configuration
- `P_MUL_SEQ_CLMUL_EN` defined: the `clmul` input is latched at accept and selects carry-less multiply.
- Not defined: the XOR path is not compiled. `clmul` is ignored, and every operation is an ordinary unsigned multiply with identical latency.

## Test plan
- **pw_32.** `lhs=0xFFFFFFFF`, `rhs=0xFFFFFFFF` → after 32 cycles `result_hi=0xFFFFFFFE`, `result_lo=0x00000001`.
- **pw_8.** `lhs=0x02FF1003`, `rhs=0x03FF1005` → after 8 cycles `result_lo=0x0601000F`, `result_hi=0x00FE0100`.
- **pw_2.** `lhs=rhs=0xFFFFFFFF` → after 2 cycles `result_lo=0x55555555`, `result_hi=0xAAAAAAAA`. Also check that `pw=0` behaves as pw_32.
- **Backpressure.** Hold `out_ready=0` for 10 cycles in DONE → outputs stable, `in_ready=0`, and `in_valid` pulses ignored. Raise `out_ready` → IDLE the next cycle.
- **Reset mid-operation.** Pulse `g_rst` at step 5 of a pw_32 operation → `out_valid` never rises, all outputs 0, `in_ready=1` the cycle after reset drops. A new pw_16 operation `0x00030003 × 0x00050005` → `result_lo=0x000F000F`, `result_hi=0`.
- **clmul, with `P_MUL_SEQ_CLMUL_EN`.** pw_32, `lhs=3`, `rhs=3`, `clmul=1` → `result_lo=0x00000005`, `result_hi=0`. The same stimulus without the macro → `result_lo=0x00000009`.
